// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared constants and types for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int          c_XLEN             = 32;
    localparam logic [31:0] c_NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: instruction word tagged with its address.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        DEC_BUBBLE = 2'd0,
        DEC_HOLD   = 2'd1,
        DEC_POP    = 2'd2
    } dec_sel_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_fetch_fifo
//  Description : Small synchronous FIFO holding {pc, instr} fetch entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt <= r_cnt + (c_AW + 1)'(push) - (c_AW + 1)'(pop);
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign cnt       = r_cnt;
    assign full      = (r_cnt == c_FULL);
    assign empty     = (r_cnt == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Fetch stage - issues in-order imem requests, buffers words,
//                feeds the decode register, handles stall and redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_D,
    output logic [31:0] instruction_D,
    output logic [31:0] pc_D,
    output logic        valid_D
);

    localparam int              c_CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW:0]   c_DEPTH_SUM = (c_CW + 1)'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_MAX_OUTST = c_CW'(MAX_OUTST);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outst;
    logic [c_CW-1:0] r_drop;
    logic [31:0]     r_instr_d;
    logic [31:0]     r_pc_d;
    logic            r_valid_d;

    logic [31:0]     w_target_pc;
    logic [c_CW:0]   w_credit_used;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_fifo_cnt;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;
    logic [63:0]     w_head_bits;
    dec_sel_e        w_dec_sel;

    assign w_target_pc   = redirect_pc & ~32'h3;
    // Words in flight plus words buffered may never exceed the buffer size.
    assign w_credit_used = {1'b0, r_outst} + {1'b0, w_fifo_cnt};

    assign imem_req_valid = !rst && !redirect_valid &&
                            (w_credit_used < c_DEPTH_SUM) && (r_outst < c_MAX_OUTST);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle belongs to the old path and is discarded.
    assign w_push       = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= r_outst + c_CW'(w_accept) - c_CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= w_target_pc;
                r_rsp_pc   <= w_target_pc;
                r_drop     <= r_outst - c_CW'(imem_rsp_valid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    if_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head_data (w_head_bits),
        .cnt       (w_fifo_cnt),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_head_entry = fetch_entry_t'(w_head_bits);

    always_comb begin
        w_dec_sel = DEC_BUBBLE;
        if (redirect_valid) begin
            w_dec_sel = DEC_BUBBLE;
        end else if (stall_D) begin
            w_dec_sel = DEC_HOLD;
        end else if (!w_fifo_empty) begin
            w_dec_sel = DEC_POP;
        end
    end

    assign w_pop = (w_dec_sel == DEC_POP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d <= c_NOP_INSTR;
            r_pc_d    <= 32'h0;
            r_valid_d <= 1'b0;
        end else begin
            case (w_dec_sel)
                DEC_POP: begin
                    r_instr_d <= w_head_entry.instr;
                    r_pc_d    <= w_head_entry.pc;
                    r_valid_d <= 1'b1;
                end
                DEC_HOLD: begin
                    r_instr_d <= r_instr_d;
                    r_pc_d    <= r_pc_d;
                    r_valid_d <= r_valid_d;
                end
                default: begin
                    r_instr_d <= c_NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
            endcase
        end
    end

    assign instruction_D = r_instr_d;
    assign pc_D          = r_pc_d;
    assign valid_D       = r_valid_d;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifo_full));
    a_rsp_credited: assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && (r_outst == '0)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit with an in-order imem model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam int          c_MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic [31:0] instruction_D;
    logic [31:0] pc_D;
    logic        valid_D;

    if_fetch_unit #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (2),
        .MAX_OUTST  (c_MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_D        (stall_D),
        .instruction_D  (instruction_D),
        .pc_D           (pc_D),
        .valid_D        (valid_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          rv;
        logic [31:0] addr;
        bit          vd;
        logic [31:0] pcd;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    mreq_t       mq[$];
    int          last_due = -1;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          rsp_pct  = 100;

    // Reference: the stream of PCs decode should see, and the next fetch address.
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          delivered = 0;
    logic [31:0] last_delivered;

    bit          prev_stall, prev_redir, prev_rv, prev_ready, prev_vd;
    logic [31:0] prev_instr, prev_pcd;

    logic        obs_rv, obs_vd;
    logic [31:0] obs_addr, obs_instr, obs_pcd;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        last_due   = -1;
        exp_pc     = c_RESET_PC;
        exp_fetch  = c_RESET_PC;
        prev_stall = 0;
        prev_redir = 0;
        prev_rv    = 0;
        prev_ready = 0;
        prev_vd    = 0;
        prev_instr = c_NOP;
        prev_pcd   = 32'h0;
    endtask

    task automatic model_check(input bit rd, input logic [31:0] rpc, input bit rdy, input int outst_before);
        if (rd) chk("req_during_redirect", obs_rv, 0);
        if (outst_before >= c_MAX_OUTST) chk("outst_limit", obs_rv, 0);
        if (obs_rv) chk("req_addr", obs_addr, exp_fetch);
        if (prev_rv && !prev_ready && !rd) chk("req_hold_valid", obs_rv, 1);

        if (prev_redir) begin
            chk("redirect_bubble_valid", obs_vd, 0);
            chk("redirect_bubble_instr", obs_instr, c_NOP);
        end else if (prev_stall) begin
            chk("stall_hold_valid", obs_vd, prev_vd);
            chk("stall_hold_pc", obs_pcd, prev_pcd);
            chk("stall_hold_instr", obs_instr, prev_instr);
        end else if (obs_vd) begin
            chk("deliver_pc", obs_pcd, exp_pc);
            chk("deliver_instr", obs_instr, instr_of(obs_pcd));
            exp_pc = exp_pc + 32'd4;
            delivered++;
            last_delivered = obs_pcd;
        end else begin
            chk("bubble_instr", obs_instr, c_NOP);
        end

        if (rd) begin
            exp_pc    = rpc & ~32'h3;
            exp_fetch = rpc & ~32'h3;
        end else if (obs_rv && rdy) begin
            exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    // One clock: drive inputs and memory response, observe, check, record accept.
    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit rdy, input bit mdl);
        int outst_before;
        int due;
        @(negedge clk);
        rst            = r;
        stall_D        = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        outst_before   = mq.size();
        if (!r && mq.size() > 0) begin
            if (mq[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mq[0].addr);
                void'(mq.pop_front());
            end
        end
        #1;
        obs_rv    = imem_req_valid;
        obs_addr  = imem_req_addr;
        obs_vd    = valid_D;
        obs_pcd   = pc_D;
        obs_instr = instruction_D;
        if (mdl && !r) model_check(rd, rpc, rdy, outst_before);
        if (!r && obs_rv && rdy) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: obs_addr, due: due});
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            reset_model();
        end else begin
            prev_stall = st;
            prev_redir = rd;
            prev_rv    = obs_rv;
            prev_ready = rdy;
            prev_vd    = obs_vd;
            prev_pcd   = obs_pcd;
            prev_instr = obs_instr;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[18];
        logic [31:0] wl[3];
        bit          rd_b;
        logic [31:0] rpc_v;
        int          d0;
        int          k;
        bit          found;

        // Cycle 0 is the first cycle with rst low; ready=1, 1-cycle memory.
        tv[0]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
        tv[1]  = '{0, 0, 32'h0,   1, 32'h4,   0, 32'h0};
        tv[2]  = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        tv[3]  = '{0, 0, 32'h0,   1, 32'h8,   1, 32'h0};
        tv[4]  = '{0, 0, 32'h0,   1, 32'hC,   1, 32'h4};
        tv[5]  = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        tv[6]  = '{1, 0, 32'h0,   1, 32'h10,  1, 32'h8};
        tv[7]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h8};
        tv[8]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h8};
        tv[9]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h8};
        tv[10] = '{0, 0, 32'h0,   1, 32'h14,  1, 32'hC};
        tv[11] = '{0, 0, 32'h0,   1, 32'h18,  1, 32'h10};
        tv[12] = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        tv[13] = '{1, 1, 32'h103, 0, 32'h0,   1, 32'h14};
        tv[14] = '{0, 0, 32'h0,   1, 32'h100, 0, 32'h0};
        tv[15] = '{0, 0, 32'h0,   1, 32'h104, 0, 32'h0};
        tv[16] = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        tv[17] = '{0, 0, 32'h0,   1, 32'h108, 1, 32'h100};

        wl[0] = 32'hFFFF_FFF8;
        wl[1] = 32'hFFFF_FFFC;
        wl[2] = 32'h0000_0000;

        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; stall_D = 1'b0;
        reset_model();

        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("reset_req_valid", obs_rv, 0);
        chk("reset_req_addr", obs_addr, c_RESET_PC);
        chk("reset_valid_D", obs_vd, 0);
        chk("reset_pc_D", obs_pcd, 32'h0);
        chk("reset_instr_D", obs_instr, c_NOP);

        for (int i = 0; i < 18; i++) begin
            step(0, tv[i].stall, tv[i].redir, tv[i].rpc, 1, 1);
            chk($sformatf("tv%0d_req_valid", i), obs_rv, tv[i].rv);
            if (tv[i].rv) chk($sformatf("tv%0d_req_addr", i), obs_addr, tv[i].addr);
            chk($sformatf("tv%0d_valid_D", i), obs_vd, tv[i].vd);
            if (tv[i].vd) begin
                chk($sformatf("tv%0d_pc_D", i), obs_pcd, tv[i].pcd);
                chk($sformatf("tv%0d_instr_D", i), obs_instr, instr_of(tv[i].pcd));
            end else begin
                chk($sformatf("tv%0d_bubble_instr", i), obs_instr, c_NOP);
            end
        end

        // Redirect while two requests are in flight.
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        lat_min = 3; lat_max = 3; rsp_pct = 100;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, 0, 0, 1, 1);
            if (mq.size() == 2) found = 1;
        end
        chk("two_outstanding_reached", found, 1);
        step(0, 0, 1, 32'h100, 1, 1);
        d0 = delivered;
        for (int i = 0; i < 30 && delivered == d0; i++) step(0, 0, 0, 0, 1, 1);
        chk("redirect_delivered", delivered > d0, 1);
        chk("redirect_first_pc", last_delivered, 32'h100);

        // Randomized traffic against the stream model.
        lat_min = 1; lat_max = 4; rsp_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(999) < 3) begin
                step(1, 0, 0, 0, 0, 0);
                step(1, 0, 0, 0, 0, 0);
            end else begin
                rd_b  = ($urandom_range(99) < 4);
                rpc_v = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
                step(0, $urandom_range(99) < 20, rd_b, rpc_v, $urandom_range(99) < 70, 1);
            end
        end

        // Drain: with a clean memory the stage must keep delivering.
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        d0 = delivered;
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1, 1);
        chk("liveness", (delivered - d0) >= 10, 1);

        // Fetch address wrap-around.
        step(0, 0, 1, 32'hFFFF_FFF8, 1, 1);
        k = 0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            d0 = delivered;
            step(0, 0, 0, 0, 1, 1);
            if (delivered != d0) begin
                chk($sformatf("wrap_seq%0d", k), last_delivered, wl[k]);
                k++;
            end
        end
        chk("wrap_count", k, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
